// File: rtl/io_out_arbiter_if.sv
// ---------------------------------------------------------------------------
// io_out_arbiter_if
// Bundle of the request side and output side of the io_o arbiter.
//   req      requester -> arbiter : per-requester level request
//   last     requester -> arbiter : early release (honoured for grantee only)
//   data_i   requester -> arbiter : requester k byte at data_i[8k+7:8k]
//   io_o     arbiter -> pins      : shared 8-bit output bus
//   grant    arbiter -> requester : one-hot grant (registered)
//   busy     arbiter -> requester : a grant is currently held (registered)
//   slot_cnt arbiter -> debug     : cycles elapsed in current slot
// master = requester/tile side, slave = arbiter.
// ---------------------------------------------------------------------------
interface io_out_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   last;
  logic [8*N_REQ-1:0] data_i;
  logic [7:0]         io_o;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [7:0]         slot_cnt;

  modport master (
    output req, last, data_i,
    input  io_o, grant, busy, slot_cnt
  );

  modport slave (
    input  req, last, data_i,
    output io_o, grant, busy, slot_cnt
  );
endinterface

// File: rtl/io_out_arbiter.sv
// ---------------------------------------------------------------------------
// io_out_arbiter
// Time-shares the tile's single 8-bit io_o bus between N_REQ sub-designs
// using round-robin arbitration with a bounded slot length.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  io_out_arbiter_if.slave: req/last/data_i in, io_o/grant/busy/slot_cnt out
// Parameters:
//   N_REQ       number of requesters (2..8)
//   SLOT_CYCLES maximum consecutive cycles one grant is held (1..255)
//   IDLE_VALUE  value driven on io_o when nothing is granted
// ---------------------------------------------------------------------------
module io_out_arbiter #(
  parameter int          N_REQ       = 4,
  parameter int          SLOT_CYCLES = 4,
  parameter logic [7:0]  IDLE_VALUE  = 8'h00
) (
  input logic              clk,
  input logic              rst,
  io_out_arbiter_if.slave  bus
);

  localparam int         PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg;
  // ptr_reg doubles as the grantee index while in HOLD: the winner of every
  // arbitration becomes both the new pointer and the new grantee.
  logic [PW-1:0]    ptr_reg;
  logic [N_REQ-1:0] grant_reg;
  logic             busy_reg;
  logic [7:0]       slot_cnt_reg;

  // -------------------------------------------------------------------------
  // Round-robin search starting at ptr+1. The current grantee is masked out,
  // so a releasing requester cannot win the back-to-back re-grant; grant_reg
  // is zero in IDLE, so the mask is a no-op there.
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0] cand;
  logic             found;
  logic [PW-1:0]    win_idx;

  assign cand = bus.req & ~grant_reg;

  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_reg) + k) % N_REQ;
      if (!found && cand[idx]) begin
        found   = 1'b1;
        win_idx = idx[PW-1:0];
      end
    end
  end

  // Release of the current grantee: request dropped, early release, or the
  // slot is used up. All three collapse into one release event, so a
  // coincident last and expiry advances the grant only once.
  logic release_now;
  assign release_now = !bus.req[ptr_reg] || bus.last[ptr_reg] ||
                       (slot_cnt_reg == SLOT_LAST);

  logic [N_REQ-1:0] win_onehot;
  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= PW'(N_REQ - 1);
      grant_reg    <= '0;
      busy_reg     <= 1'b0;
      slot_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg    <= HOLD;
            ptr_reg      <= win_idx;
            grant_reg    <= win_onehot;
            busy_reg     <= 1'b1;
            slot_cnt_reg <= 8'd0;
          end
        end
        HOLD: begin
          if (!release_now) begin
            slot_cnt_reg <= slot_cnt_reg + 8'd1;
          end else if (found) begin
            // back-to-back hand-over, no idle cycle on io_o
            ptr_reg      <= win_idx;
            grant_reg    <= win_onehot;
            slot_cnt_reg <= 8'd0;
          end else begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            busy_reg     <= 1'b0;
            slot_cnt_reg <= 8'd0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          grant_reg    <= '0;
          busy_reg     <= 1'b0;
          slot_cnt_reg <= 8'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output mux: AND-OR of each requester byte with its grant bit. Driven from
  // the registered grant, so io_o only moves when data_i or the grant moves.
  // -------------------------------------------------------------------------
  logic [7:0] masked [N_REQ];
  logic [7:0] io_mux;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign masked[gi] = bus.data_i[8*gi +: 8] & {8{grant_reg[gi]}};
    end
  endgenerate

  always_comb begin
    io_mux = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      io_mux = io_mux | masked[k];
    end
  end

  assign bus.io_o     = busy_reg ? io_mux : IDLE_VALUE;
  assign bus.grant    = grant_reg;
  assign bus.busy     = busy_reg;
  assign bus.slot_cnt = slot_cnt_reg;

  // grant must never have more than one bit set
  grant_onehot0_a: assert property (@(posedge clk) disable iff (rst)
                                    $onehot0(grant_reg));

endmodule

// File: tb/tb_io_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_out_arbiter
// Two arbiters share one stimulus stream: dut_a with SLOT_CYCLES=4 and dut_b
// with SLOT_CYCLES=2. A behavioural model (holder / slot age / pointer) runs
// beside each and is compared every falling edge; directed literal checks
// pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_io_out_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_out_arbiter_if #(.N_REQ(N)) bus_a ();
  io_out_arbiter_if #(.N_REQ(N)) bus_b ();

  io_out_arbiter #(.N_REQ(N), .SLOT_CYCLES(4), .IDLE_VALUE(8'h00)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  io_out_arbiter #(.N_REQ(N), .SLOT_CYCLES(2), .IDLE_VALUE(8'h00)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------- model --
  typedef struct {
    int holder;  // -1 when nothing is granted
    int cnt;     // cycles elapsed in current slot
    int ptr;     // last winner
  } mstate_t;

  function automatic mstate_t model_step(mstate_t s, logic [N-1:0] r,
                                         logic [N-1:0] l, int slots);
    mstate_t n;
    n = s;
    if (s.holder >= 0 && r[s.holder] && !l[s.holder] && s.cnt != slots - 1) begin
      n.cnt = s.cnt + 1;
      return n;
    end
    // arbitration: first requester after ptr, never the one just releasing
    n.holder = -1;
    n.cnt    = 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (s.ptr + k) % N;
      if (r[c] && c != s.holder) begin
        n.holder = c;
        n.ptr    = c;
        break;
      end
    end
    return n;
  endfunction

  mstate_t ma = '{-1, 0, N - 1};
  mstate_t mb = '{-1, 0, N - 1};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '{-1, 0, N - 1};
      mb <= '{-1, 0, N - 1};
    end else begin
      ma <= model_step(ma, bus_a.req, bus_a.last, 4);
      mb <= model_step(mb, bus_b.req, bus_b.last, 2);
    end
  end

  task automatic compare_dut(input string tag, input mstate_t m,
                             input logic [N-1:0] g, input logic b,
                             input logic [7:0] sc, input logic [7:0] io,
                             input logic [8*N-1:0] d);
    logic [N-1:0] eg;
    logic [7:0]   eio;
    logic         eb;
    eg  = (m.holder >= 0) ? (N'(1) << m.holder) : '0;
    eio = (m.holder >= 0) ? d[8*m.holder +: 8] : 8'h00;
    eb  = (m.holder >= 0);
    n_cmp++;
    if (g !== eg || b !== eb || sc !== 8'(m.cnt) || io !== eio) begin
      n_fail++;
      $display("FAIL model_%s t=%0t: grant=%b busy=%b slot_cnt=%0d io_o=%h, required grant=%b busy=%b slot_cnt=%0d io_o=%h",
               tag, $time, g, b, sc, io, eg, eb, m.cnt, eio);
    end
    n_cmp++;
    if (!$onehot0(g)) begin
      n_fail++;
      $display("FAIL onehot_%s t=%0t: grant=%b, required at most one bit set", tag, $time, g);
    end
  endtask

  always @(negedge clk) begin
    compare_dut("a", ma, bus_a.grant, bus_a.busy, bus_a.slot_cnt, bus_a.io_o, bus_a.data_i);
    compare_dut("b", mb, bus_b.grant, bus_b.busy, bus_b.slot_cnt, bus_b.io_o, bus_b.data_i);
  end

  // -------------------------------------------------------------- helpers --
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [8*N-1:0] d);
    bus_a.req = r;  bus_a.last = l;  bus_a.data_i = d;
    bus_b.req = r;  bus_b.last = l;  bus_b.data_i = d;
  endtask

  // advance to 2 time units after the next rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // ------------------------------------------------------------- stimulus --
  initial begin
    drive(4'b0000, 4'b0000, 32'h0);
    tick(2);
    check("rst_grant", int'(bus_a.grant), 0);
    check("rst_busy", int'(bus_a.busy), 0);
    check("rst_io", int'(bus_a.io_o), 0);
    rst = 1'b0;

    // 1: single requester, 4 on / 1 off
    drive(4'b0001, 4'b0000, 32'h0000_00A5);
    tick(1);
    $display("t1 first grant: grant=%b io_o=%h", bus_a.grant, bus_a.io_o);
    check("t1_grant", int'(bus_a.grant), 1);
    check("t1_io", int'(bus_a.io_o), 'hA5);
    check("t1_slot0", int'(bus_a.slot_cnt), 0);
    tick(3);
    check("t1_slot3", int'(bus_a.slot_cnt), 3);
    tick(1);
    check("t1_gap_grant", int'(bus_a.grant), 0);
    check("t1_gap_io", int'(bus_a.io_o), 0);
    tick(1);
    check("t1_regrant", int'(bus_a.grant), 1);
    drive(4'b0000, 4'b0000, 32'h0000_00A5);
    tick(2);

    // 2: all requesting, 4-cycle rotation with pointer wrap
    do_reset();
    drive(4'b1111, 4'b0000, 32'h4433_2211);
    for (int t = 1; t <= 17; t++) begin
      int q;
      tick(1);
      q = ((t - 1) / 4) % 4;
      check($sformatf("t2_grant_c%0d", t), int'(bus_a.grant), 1 << q);
      check($sformatf("t2_io_c%0d", t), int'(bus_a.io_o), 'h11 * (q + 1));
    end
    $display("t2 rotation done: grant=%b io_o=%h", bus_a.grant, bus_a.io_o);
    drive(4'b0000, 4'b0000, 32'h4433_2211);
    tick(2);

    // 3: early release of requester 0 in its 2nd cycle
    do_reset();
    drive(4'b0011, 4'b0000, 32'h4433_2211);
    tick(1);
    check("t3_grant0", int'(bus_a.grant), 1);
    tick(1);
    check("t3_grant0_c2", int'(bus_a.grant), 1);
    check("t3_slot1", int'(bus_a.slot_cnt), 1);
    drive(4'b0011, 4'b0001, 32'h4433_2211);
    tick(1);
    $display("t3 after last: grant=%b slot_cnt=%0d", bus_a.grant, bus_a.slot_cnt);
    check("t3_grant1", int'(bus_a.grant), 2);
    check("t3_slot_reset", int'(bus_a.slot_cnt), 0);

    // 4: grantee drops, hand-over to 2; last on others ignored; drop to idle
    drive(4'b0100, 4'b0000, 32'h4433_2211);
    tick(1);
    check("t4_grant2", int'(bus_a.grant), 4);
    check("t4_io", int'(bus_a.io_o), 'h33);
    drive(4'b0100, 4'b0011, 32'h4433_2211);
    tick(1);
    check("t4_last_ignored", int'(bus_a.grant), 4);
    check("t4_slot1", int'(bus_a.slot_cnt), 1);
    drive(4'b0000, 4'b0000, 32'h4433_2211);
    tick(1);
    $display("t4 drop: grant=%b busy=%b", bus_a.grant, bus_a.busy);
    check("t4_idle_grant", int'(bus_a.grant), 0);
    check("t4_idle_busy", int'(bus_a.busy), 0);

    // 5: asynchronous reset in the middle of a slot
    drive(4'b1000, 4'b0000, 32'h4433_2211);
    tick(1);
    check("t5_grant3", int'(bus_a.grant), 8);
    tick(2);
    check("t5_slot2", int'(bus_a.slot_cnt), 2);
    #1 rst = 1'b1;
    drive(4'b1001, 4'b0000, 32'h4433_2211);
    #1;
    $display("t5 async reset: grant=%b io_o=%h", bus_a.grant, bus_a.io_o);
    check("t5_rst_grant", int'(bus_a.grant), 0);
    check("t5_rst_io", int'(bus_a.io_o), 0);
    check("t5_rst_slot", int'(bus_a.slot_cnt), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick(1);
    check("t5_req0_first", int'(bus_a.grant), 1);
    drive(4'b0000, 4'b0000, 32'h4433_2211);
    tick(2);

    // 6: last and expiry together on dut_b (SLOT_CYCLES=2)
    do_reset();
    drive(4'b0110, 4'b0000, 32'h4433_2211);
    tick(1);
    check("t6_b_grant1", int'(bus_b.grant), 2);
    tick(1);
    check("t6_b_slot1", int'(bus_b.slot_cnt), 1);
    drive(4'b0110, 4'b0010, 32'h4433_2211);
    tick(1);
    $display("t6 coincident release: grant=%b slot_cnt=%0d", bus_b.grant, bus_b.slot_cnt);
    check("t6_b_grant2", int'(bus_b.grant), 4);
    check("t6_b_slot0", int'(bus_b.slot_cnt), 0);
    drive(4'b0110, 4'b0000, 32'h4433_2211);
    tick(1);
    check("t6_b_hold", int'(bus_b.grant), 4);
    check("t6_b_hold_slot", int'(bus_b.slot_cnt), 1);
    tick(1);
    check("t6_b_back", int'(bus_b.grant), 2);
    drive(4'b0000, 4'b0000, 32'h4433_2211);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_out_arbiter.md
Name: io_out_arbiter

Overview:
- Time-shares the single 8-bit `io_o` pin bus between N_REQ internal sub-designs of one tile.
- Arbitration is round-robin with a bounded time slot. The granted requester's byte is steered onto `io_o`; all other requesters wait.
- Sits between the sub-design cores and the tile's top-level `io_o` output.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SLOT_CYCLES, 4, maximum consecutive cycles one grant is held (1..255).
- IDLE_VALUE, 8'h00, value driven on `io_o` when nothing is granted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request, level-sensitive.
- last  input  N_REQ  per-requester early release; sampled only for the current grantee.
- data_i  input  8*N_REQ  requester bytes; requester k uses data_i[8k+7:8k].
- io_o  output  8  shared output bus.
- grant  output  N_REQ  one-hot grant, registered.
- busy  output  1  high while any grant is held, registered.
- slot_cnt  output  8  cycles elapsed in the current slot, registered, for debug.

Behaviour:
- Reset (async, immediate):
  - grant=0, busy=0, slot_cnt=0, io_o=IDLE_VALUE.
  - Round-robin pointer ptr=N_REQ-1, so requester 0 has first priority.
- State machine: IDLE, HOLD.
  - `busy` = (state==HOLD). `grant` is nonzero only in HOLD.
- IDLE:
  - If any req bit is set, on the next edge: grant the first requester with req set, searching ptr+1, ptr+2, … modulo N_REQ.
  - Then set ptr to the winner, slot_cnt=0, state=HOLD.
  - Request-to-grant latency is 1 cycle.
  - If no req bit is set, stay in IDLE.
- HOLD (grantee g):
  - Release condition, evaluated each cycle: req[g]==0, OR last[g]==1, OR slot_cnt==SLOT_CYCLES-1.
  - If no release: slot_cnt increments.
  - On release with another requester pending (any req excluding g): the next edge grants the next requester in round-robin order from ptr=g. This is back-to-back with no idle cycle; slot_cnt=0.
  - On release with nothing else pending: state=IDLE, grant=0.
  - g is excluded from the immediate re-grant search even if req[g] is still high. It may be re-granted only from IDLE on a later cycle.
- io_o:
  - Combinational mux from the registered grant: data_i of the grantee while in HOLD, else IDLE_VALUE.
  - No glitching beyond data_i changes, because grant is a register.
- Boundary conditions:
  - last[g] and slot expiry in the same cycle: a single release; no double advance.
  - SLOT_CYCLES=1: every grant lasts exactly 1 cycle, giving a strict rotation among active requesters.
  - req of a non-granted requester dropping mid-slot has no effect.
  - last on a non-granted requester is ignored.
  - ptr wraps N_REQ-1 → 0.
  - rst asserted mid-slot returns everything to reset values immediately. The next arbitration after deassertion again favours requester 0.
  - slot_cnt never reaches SLOT_CYCLES.
  - `grant` is always one-hot or zero (checker assertion).

Test Plan:
1. Reset, then req=4'b0001 held, data_i[7:0]=8'hA5:
   - Cycle 1: grant=0001, io_o=A5.
   - slot_cnt counts 0..3.
   - After 4 grant cycles: back to IDLE for 1 cycle, then regrant. No other requester is pending, so the pattern is 4 on / 1 off.
2. req=4'b1111 held, data bytes 11/22/33/44:
   - grant rotates 0001→0010→0100→1000→0001, each exactly 4 cycles, with no gaps.
   - io_o follows 11,22,33,44.
3. Early release with req=4'b0011, pulse last[0] in the 2nd grant cycle:
   - Requester 0 holds 2 cycles.
   - Requester 1 is granted on the next edge with slot_cnt=0.
4. Requester drop: grant=0100, deassert req[2] → next edge grant=0 and busy=0, or the next pending requester is granted.
5. Reset mid-slot: req=4'b1000 granted, slot_cnt=2, assert rst asynchronously:
   - grant=0, io_o=00 immediately.
   - After release, with req=4'b1001, requester 0 wins first.
6. Simultaneous last[g] and slot expiry with SLOT_CYCLES=2, req=4'b0110:
   - Exactly one advance: grant 0010 → 0100.
   - slot_cnt resets to 0.
   - Never more than one grant bit set.
